mic_pdm_rx: RTL and testbench
=============================

# mic_pdm_rx

PDM microphone receiver: the capture-side counterpart of the PWM audio output path. Generates the microphone bit clock from the system clock, samples the 1-bit PDM stream, and decimates it by ones-counting over a fixed window into 8-bit unsigned amplitude samples. The output has the same format as the `value` input of the audio output block, so captured audio can be looped straight back to the speaker or fed to the sample generators.

## Interface
- `HALF_PERIOD`, default 25: system clocks per M_CLK phase. M_CLK period is 2*HALF_PERIOD clocks, i.e. 2 MHz at 100 MHz. Legal range 2..255.
- `WINDOW_LOG2`, default 8: log2 of PDM samples per output sample. Legal range 8..12.
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: asynchronous active-low reset.
- `M_DATA` input 1: PDM data from the microphone.
- `M_CLK` output 1: microphone bit clock, registered.
- `M_LRSEL` output 1: channel select, constant 0. With 0, data is valid while M_CLK is high.
- `value` output 8: last decimated sample, unsigned, registered.
- `valid` output 1: one-cycle pulse when `value` updates.

## Operation
- Divider: counter `div` runs 0..HALF_PERIOD-1. At terminal count, M_CLK toggles and `div` returns to 0.
- Sample point: the clk edge where `div` is at terminal count and M_CLK==1, the same edge that drives M_CLK low. The sampled bit is M_DATA, or the synchronized bit if the macro below is enabled.
- Accumulator:
  - `ones` has width WINDOW_LOG2+1 and counts sampled 1s.
  - `nsamp` has width WINDOW_LOG2 and counts samples, wrapping naturally.
- Window close: on the sample point where `nsamp` == 2^WINDOW_LOG2-1:
  - total = `ones` + bit, where bit is the current sample.
  - `value` <= saturate255(total >> (WINDOW_LOG2-8)).
  - `valid` <= 1.
  - `ones` <= 0.
  - `nsamp` wraps to 0.
  - The current bit belongs to the closing window.
- Saturation: only an all-ones window reaches 256 after the shift; it is clamped to 255.
- `valid` is 0 on all other cycles. `value` holds between windows.
- No backpressure. A consumer that misses `valid` still reads the held `value`.

## Timing
- Reset values: M_CLK=0, M_LRSEL=0, value=0, valid=0, div=0, ones=0, nsamp=0, synchronizer flops=0.
- Reset is asynchronous: all state clears immediately on assertion, including mid-window. A partial window is discarded.
- After rst_n deasserts (first active edge = cycle 1):
  - M_CLK rises at cycle HALF_PERIOD.
  - M_CLK falls at cycle 2*HALF_PERIOD, which is the first sample point.
- Sample points are every 2*HALF_PERIOD clocks.
- `valid` rises one cycle after the 2^WINDOW_LOG2-th sample point and lasts exactly 1 cycle. First valid is at cycle 2^WINDOW_LOG2*2*HALF_PERIOD+1 (12801 with defaults). Output period is 12800 clocks (7.8125 kHz).
- Latency from the last sample of a window to `value`: 1 clock.

## Configuration
- `MIC_PDM_SYNC_EN` defined:
  - M_DATA passes through a 2-flop synchronizer clocked by `clk`; the sample point reads the second flop.
  - The effective sampling instant is 2 clocks earlier relative to M_CLK. Cycle timing of M_CLK, valid and value is unchanged.
- `MIC_PDM_SYNC_EN` undefined:
  - M_DATA is sampled directly at the sample point.

## Test plan
- Defaults, M_DATA=1 constant -> M_CLK period 50 clocks with 25/25 duty; valid pulses every 12800 clocks with value=255 (saturated).
- M_DATA=0 constant -> value=0 at every valid; first valid at cycle 12801 after reset release.
- M_DATA toggled at each sample point, starting with 1 -> value=128 every window.
- Bench model driving exactly 64 ones per 256-sample window -> value=64. With WINDOW_LOG2=9 and 128 ones per 512 samples -> value=64, valid every 25600 clocks.
- rst_n pulsed low mid-window (at sample 100) -> M_CLK, value and valid go to 0 asynchronously; after release, the next valid arrives 12801 cycles later and reflects only post-reset samples.
- With MIC_PDM_SYNC_EN, M_DATA pattern changing 1 clock before a sample point -> the change is not captured at that point; it is captured at the following sample point.

Source files
------------

// File: rtl/mic_pdm_rx.sv
// mic_pdm_rx: PDM microphone receiver, M_CLK generation plus ones-count decimation to 8-bit samples
//   Optional feature macro: MIC_PDM_SYNC_EN (2-flop synchronizer on M_DATA)
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   M_DATA  : PDM bit stream from the microphone
//   M_CLK   : microphone bit clock, 2*HALF_PERIOD clk periods
//   M_LRSEL : channel select, tied 0 (data valid while M_CLK is high)
//   value   : last decimated unsigned sample
//   valid   : one-cycle pulse when value updates
module mic_pdm_rx #(
    parameter int HALF_PERIOD = 25,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       M_DATA,
    output logic       M_CLK,
    output logic       M_LRSEL,
    output logic [7:0] value,
    output logic       valid
);
    logic [7:0]             div;
    logic [WINDOW_LOG2:0]   ones;
    logic [WINDOW_LOG2-1:0] nsamp;
    logic                   smp_bit;
    logic                   tc;
    logic                   samp;
    logic [WINDOW_LOG2:0]   total;
    logic [WINDOW_LOG2:0]   shifted;
    logic [7:0]             sat;

`ifdef MIC_PDM_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], M_DATA};
    end
    assign smp_bit = sync_q[1];
`else
    assign smp_bit = M_DATA;
`endif

    assign M_LRSEL = 1'b0;
    assign tc      = div == 8'(HALF_PERIOD - 1);
    // sampling on the edge that drives M_CLK low, i.e. while it is still high
    assign samp    = tc & M_CLK;
    assign total   = ones + {{WINDOW_LOG2{1'b0}}, smp_bit};
    assign shifted = total >> (WINDOW_LOG2 - 8);
    // only an all-ones window can reach 256 after the shift
    assign sat     = shifted > (WINDOW_LOG2+1)'(255) ? 8'hFF : shifted[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            M_CLK <= 1'b0;
            ones  <= '0;
            nsamp <= '0;
            value <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            div   <= tc ? '0 : div + 8'd1;
            if (tc) M_CLK <= ~M_CLK;
            if (samp) begin
                nsamp <= nsamp + WINDOW_LOG2'(1);
                if (&nsamp) begin
                    ones  <= '0;
                    value <= sat;
                    valid <= 1'b1;
                end else begin
                    ones  <= total;
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_pdm_rx.sv
// tb_mic_pdm_rx: scoreboard bench for mic_pdm_rx with two parameterisations sharing one clock
module tb_mic_pdm_rx;
    localparam int HP0 = 25, W0 = 8, HP1 = 2, W1 = 9;
    localparam int PLEN = 12860;
`ifdef MIC_PDM_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {int v; int e;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 1;
    int   errs_m = 0;
    int   chks_m = 0;

    always #5 clk = ~clk;

    function automatic int dir(int m);
        return m == 0 ? 0 : m == 1 ? 255 : m == 2 ? 128 : 64;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int HP = g == 0 ? HP0 : HP1;
        localparam int W  = g == 0 ? W0 : W1;
        localparam int P  = 2 * HP;
        localparam int N  = 1 << W;

        logic       m_data = 1'b0;
        logic       m_clk;
        logic       m_lrsel;
        logic       valid;
        logic [7:0] value;
        exp_t       q[$];
        int         errs = 0, chks = 0, nval = 0;
        bit         pat[N];
        logic [1:0] h;
        int         n, wn, wo, e, s, b, mcyc, lastv;
        bit         first = 1'b1;

        mic_pdm_rx #(.HALF_PERIOD(HP), .WINDOW_LOG2(W)) dut (
            .clk(clk), .rst_n(rst_n), .M_DATA(m_data),
            .M_CLK(m_clk), .M_LRSEL(m_lrsel), .value(value), .valid(valid)
        );

        task automatic check(string nm, int act, int exp);
            chks++;
            if (act != exp) begin
                errs++;
                $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, g, $time, act, exp);
            end
        endtask

        // stimulus and reference model: each negedge drives and models the coming edge e
        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n = 0; h = '0; wn = 0; wo = 0; m_data = 1'b0;
                q.delete();
            end else begin
                n++;
                e = n + 1;
                if (e % P == HP) begin
                    s = (e + HP) / P - 1;
                    if (mode == 3 && s % N == 0) begin
                        for (int i = 0; i < N; i++) pat[i] = i < N / 4;
                        for (int i = N - 1; i > 0; i--) begin
                            int j;
                            bit t;
                            j = $urandom_range(i, 0);
                            t = pat[i]; pat[i] = pat[j]; pat[j] = t;
                        end
                    end
                    m_data = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? logic'(s % 2 == 0) :
                             mode == 3 ? logic'(pat[s % N]) : logic'($urandom % 2);
                end else if (mode == 4 && e % P == 0 && $urandom % 2 == 1) begin
                    m_data = ~m_data;
                end
                if (e % P == 0) begin
                    b = SYNC ? int'(h[1]) : int'(m_data);
                    wo += b;
                    wn++;
                    if (wn == N) begin
                        q.push_back('{v: (wo >> (W - 8)) > 255 ? 255 : (wo >> (W - 8)), e: e});
                        wn = 0; wo = 0;
                    end
                end
                h = {h[0], m_data};
            end
        end

        // monitor: outputs sampled 1 time unit after each active edge
        always @(posedge clk) begin
            #1;
            if (!rst_n) begin
                mcyc = 0; lastv = 0; first = 1'b1;
            end else begin
                mcyc++;
            end
            check("M_CLK", m_clk, (mcyc / HP) % 2);
            check("M_LRSEL", m_lrsel, 0);
            if (valid) begin
                nval++;
                if (q.size() == 0 || !rst_n) begin
                    chks++; errs++;
                    $display("FAIL spurious_valid dut%0d t=%0t: got valid=1 expected valid=0", g, $time);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("value", value, x.v);
                    check("valid_edge", mcyc, x.e);
                    if (first) check("first_valid_cycle", mcyc + 1, N * P + 1);
                    if (mode < 4) check("value_directed", value, dir(mode));
                    first = 1'b0;
                    lastv = x.v;
                end
            end else begin
                check("value_hold", value, lastv);
            end
        end
    end

    task automatic chk_m(string nm, int act, int exp);
        chks_m++;
        if (act != exp) begin
            errs_m++;
            $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_and_check(int len);
        int a0, a1;
        a0 = u[0].nval;
        a1 = u[1].nval;
        repeat (len) @(posedge clk);
        #2;
        chk_m("valid_count_dut0", u[0].nval - a0, len / (2 * HP0 * (1 << W0)));
        chk_m("valid_count_dut1", u[1].nval - a1, len / (2 * HP1 * (1 << W1)));
        chk_m("pending_dut0", u[0].q.size(), 0);
        chk_m("pending_dut1", u[1].q.size(), 0);
    endtask

    initial begin
        for (int m = 0; m < 5; m++) begin
            mode = m == 0 ? 1 : m == 1 ? 0 : m;
            do_reset();
            run_and_check(PLEN);
        end
        // mid-window asynchronous reset around sample 100 of the second window of dut0
        repeat (2 * HP0 * (1 << W0) + 5030 - PLEN) @(posedge clk);
        chk_m("pre_reset_mclk_dut0", u[0].m_clk, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_m("async_mclk_dut0", u[0].m_clk, 0);
        chk_m("async_value_dut0", u[0].value, 0);
        chk_m("async_valid_dut0", u[0].valid, 0);
        chk_m("async_mclk_dut1", u[1].m_clk, 0);
        chk_m("async_value_dut1", u[1].value, 0);
        chk_m("async_valid_dut1", u[1].valid, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        run_and_check(PLEN);
        $display("Simulation finished: %0d checks, %0d errors",
                 chks_m + u[0].chks + u[1].chks, errs_m + u[0].errs + u[1].errs);
        $finish;
    end
endmodule
